// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Multi-cycle ALU execution unit with an internal register file.
//               Each command passes through IDLE -> READ -> EXEC -> WRITE.
//               The unit accepts one command every four cycles, and the result
//               pulse (done) appears three edges after the accept edge.
// Ports       : clk, reset (async, active-high)
//               cmd_valid/cmd_ready  - command handshake
//               cmd {op,rd,rs1,rs2}  - operation and register indices
//               cmd_imm              - immediate used by LDI only
//               busy, done           - in-flight status, completion pulse
//               result, O/C/Z/N      - last written result and its flags
//               disp_value           - live contents of register DISP_REG
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 8,
    parameter int DISP_REG = 7,
    localparam int RW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [3+3*RW-1:0]   cmd,
    input  logic [WIDTH-1:0]    cmd_imm,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic                O,
    output logic                C,
    output logic                Z,
    output logic                N,
    output logic [WIDTH-1:0]    disp_value
);

    localparam int SW  = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] c_op_add = 3'b000;
    localparam logic [2:0] c_op_sub = 3'b001;
    localparam logic [2:0] c_op_and = 3'b010;
    localparam logic [2:0] c_op_or  = 3'b011;
    localparam logic [2:0] c_op_xor = 3'b100;
    localparam logic [2:0] c_op_sll = 3'b101;
    localparam logic [2:0] c_op_srl = 3'b110;
    localparam logic [2:0] c_op_ldi = 3'b111;

    localparam logic [RW-1:0] c_disp_idx = DISP_REG[RW-1:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    // Latched command fields
    logic [2:0]         r_op;
    logic [RW-1:0]      r_rd;
    logic [RW-1:0]      r_rs1;
    logic [RW-1:0]      r_rs2;
    logic [WIDTH-1:0]   r_imm;

    // Operands and staged EXEC result
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res_q;
    logic               r_o_q;
    logic               r_c_q;

    // Architectural outputs
    logic [WIDTH-1:0]   r_result;
    logic               r_o;
    logic               r_c;
    logic               r_z;
    logic               r_n;
    logic               r_done;

    logic [WIDTH-1:0]   r_regs [NREGS];

    logic               w_accept;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_o;

    assign cmd_ready  = (r_state == S_IDLE);
    assign busy       = !cmd_ready;
    assign w_accept   = cmd_valid && cmd_ready;
    assign done       = r_done;
    assign result     = r_result;
    assign O          = r_o;
    assign C          = r_c;
    assign Z          = r_z;
    assign N          = r_n;
    assign disp_value = r_regs[c_disp_idx];

    // Next-state logic: only IDLE waits, the rest advance unconditionally
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_READ;
            S_READ:  w_state_next = S_EXEC;
            S_EXEC:  w_state_next = S_WRITE;
            S_WRITE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ALU datapath operating on the latched operands
    always_comb begin
        w_sum  = {1'b0, r_a} + {1'b0, r_b};
        w_diff = r_a - r_b;
        w_res  = '0;
        w_c    = 1'b0;
        w_o    = 1'b0;
        case (r_op)
            c_op_add: begin
                w_res = w_sum[MSB:0];
                w_c   = w_sum[WIDTH];
                w_o   = (r_a[MSB] == r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
            end
            c_op_sub: begin
                w_res = w_diff;
                w_c   = (r_a < r_b);
                w_o   = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
            end
            c_op_and: w_res = r_a & r_b;
            c_op_or:  w_res = r_a | r_b;
            c_op_xor: w_res = r_a ^ r_b;
            // Only the low log2(WIDTH) bits of B form the shift amount
            c_op_sll: w_res = r_a << r_b[SW-1:0];
            c_op_srl: w_res = r_a >> r_b[SW-1:0];
            c_op_ldi: w_res = r_imm;
            default:  w_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_rd     <= '0;
            r_rs1    <= '0;
            r_rs2    <= '0;
            r_imm    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_res_q  <= '0;
            r_o_q    <= 1'b0;
            r_c_q    <= 1'b0;
            r_result <= '0;
            r_o      <= 1'b0;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_done   <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            // done is registered so it is high in the cycle after the WRITE edge
            r_done  <= (r_state == S_WRITE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op  <= cmd[3*RW+2 -: 3];
                        r_rd  <= cmd[3*RW-1 -: RW];
                        r_rs1 <= cmd[2*RW-1 -: RW];
                        r_rs2 <= cmd[RW-1:0];
                        r_imm <= cmd_imm;
                    end
                end
                S_READ: begin
                    r_a <= r_regs[r_rs1];
                    r_b <= r_regs[r_rs2];
                end
                S_EXEC: begin
                    r_res_q <= w_res;
                    r_o_q   <= w_o;
                    r_c_q   <= w_c;
                end
                S_WRITE: begin
                    r_regs[r_rd] <= r_res_q;
                    r_result     <= r_res_q;
                    r_o          <= r_o_q;
                    r_c          <= r_c_q;
                    r_z          <= (r_res_q == '0);
                    r_n          <= r_res_q[MSB];
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed self-checking bench for alu_exec_unit (32-bit, 8 regs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] SLL = 3'b101;
    localparam logic [2:0] SRL = 3'b110;
    localparam logic [2:0] LDI = 3'b111;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [11:0] cmd;
    logic [31:0] cmd_imm;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        O, C, Z, N;
    logic [31:0] disp_value;

    int errors = 0;
    int checks = 0;

    alu_exec_unit #(.WIDTH(32), .NREGS(8), .DISP_REG(7)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd        (cmd),
        .cmd_imm    (cmd_imm),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .O          (O),
        .C          (C),
        .Z          (Z),
        .N          (N),
        .disp_value (disp_value)
    );

    always #5 clk = ~clk;

    // Issue one command (called 1 time unit after a rising edge) and wait for done.
    // lat counts edges from accept to the done sample; nbusy counts busy samples.
    task automatic run_cmd(input logic [2:0] op, input logic [2:0] rd,
                           input logic [2:0] rs1, input logic [2:0] rs2,
                           input logic [31:0] imm, output int lat, output int nbusy);
        int guard = 0;
        while (!cmd_ready && guard < 10) begin
            @(posedge clk); #1; guard++;
        end
        cmd_valid = 1'b1;
        cmd       = {op, rd, rs1, rs2};
        cmd_imm   = imm;
        @(posedge clk); #1;
        // Scramble the inputs: the unit must use only its latched copy
        cmd_valid = 1'b0;
        cmd       = ~{op, rd, rs1, rs2};
        cmd_imm   = ~imm;
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 10) begin
            if (busy && !cmd_ready) nbusy++;
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd = '0; cmd_imm = '0;
        #2;
        checks++;
        if ({result, O, C, Z, N, done, busy, cmd_ready} !== {32'd0, 4'b0000, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: got res=%h ocnz=%b%b%b%b done=%b busy=%b ready=%b, want zeros and ready=1",
                     result, O, C, Z, N, done, busy, cmd_ready);
        end
        checks++;
        if (disp_value !== 32'd0) begin
            errors++; $display("FAIL reset_disp: got %h want 0", disp_value);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_add();
        int lat, nb;
        run_cmd(LDI, 3'd1, 3'd0, 3'd0, 32'd5, lat, nb);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL ldi_latency: got %0d want 3", lat); end
        checks++;
        if (nb !== 3) begin errors++; $display("FAIL ldi_busy_cycles: got %0d want 3", nb); end
        checks++;
        if (result !== 32'd5) begin errors++; $display("FAIL ldi_result: got %h want 5", result); end
        run_cmd(LDI, 3'd2, 3'd0, 3'd0, 32'd3, lat, nb);
        run_cmd(ADD, 3'd3, 3'd1, 3'd2, 32'd0, lat, nb);
        checks++;
        if (lat !== 3 || nb !== 3) begin
            errors++; $display("FAIL add_timing: got lat=%0d busy=%0d want 3/3", lat, nb);
        end
        checks++;
        if (result !== 32'd8) begin errors++; $display("FAIL add_result: got %h want 8", result); end
        checks++;
        if ({O, C, Z, N} !== 4'b0000) begin
            errors++; $display("FAIL add_flags: got ocnz=%b%b%b%b want 0000", O, C, Z, N);
        end
        // done is a single-cycle pulse and the unit is ready again
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL done_pulse: got done=%b ready=%b want 0/1", done, cmd_ready);
        end
        checks++;
        if (result !== 32'd8) begin errors++; $display("FAIL result_hold: got %h want 8", result); end
    endtask

    task automatic test_overflow();
        int lat, nb;
        run_cmd(LDI, 3'd1, 3'd0, 3'd0, 32'h7FFF_FFFF, lat, nb);
        run_cmd(LDI, 3'd2, 3'd0, 3'd0, 32'h0000_0001, lat, nb);
        run_cmd(ADD, 3'd7, 3'd1, 3'd2, 32'd0, lat, nb);
        checks++;
        if (result !== 32'h8000_0000) begin errors++; $display("FAIL ovf_result: got %h want 80000000", result); end
        checks++;
        if ({O, C, Z, N} !== 4'b1001) begin
            errors++; $display("FAIL ovf_flags: got ocnz=%b%b%b%b want 1001", O, C, Z, N);
        end
        checks++;
        if (disp_value !== 32'h8000_0000) begin errors++; $display("FAIL ovf_disp: got %h want 80000000", disp_value); end
        // Unsigned carry-out with zero result
        run_cmd(LDI, 3'd1, 3'd0, 3'd0, 32'hFFFF_FFFF, lat, nb);
        run_cmd(ADD, 3'd3, 3'd1, 3'd2, 32'd0, lat, nb);
        checks++;
        if (result !== 32'd0 || {O, C, Z, N} !== 4'b0110) begin
            errors++; $display("FAIL carry_add: got res=%h ocnz=%b%b%b%b want 0/0110", result, O, C, Z, N);
        end
    endtask

    task automatic test_async_reset();
        // Outputs are nonzero here (r7 = 0x80000000); reset must clear them before any edge
        reset = 1'b1;
        #1;
        checks++;
        if ({result, O, C, Z, N, done, busy, cmd_ready} !== {32'd0, 4'b0000, 1'b0, 1'b0, 1'b1}
            || disp_value !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got res=%h ocnz=%b%b%b%b ready=%b disp=%h want zeros",
                     result, O, C, Z, N, cmd_ready, disp_value);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        int lat, nb;
        run_cmd(LDI, 3'd1, 3'd0, 3'd0, 32'd5, lat, nb);
        run_cmd(LDI, 3'd2, 3'd0, 3'd0, 32'd3, lat, nb);
        run_cmd(SUB, 3'd3, 3'd2, 3'd1, 32'd0, lat, nb);
        checks++;
        if (result !== 32'hFFFF_FFFE || {O, C, Z, N} !== 4'b0101) begin
            errors++; $display("FAIL sub_borrow: got res=%h ocnz=%b%b%b%b want fffffffe/0101", result, O, C, Z, N);
        end
        run_cmd(SUB, 3'd4, 3'd1, 3'd1, 32'd0, lat, nb);
        checks++;
        if (result !== 32'd0 || {O, C, Z, N} !== 4'b0010) begin
            errors++; $display("FAIL sub_zero: got res=%h ocnz=%b%b%b%b want 0/0010", result, O, C, Z, N);
        end
    endtask

    task automatic test_alias();
        int lat, nb;
        // rd == rs1 == rs2: operands are the pre-write value 5
        run_cmd(ADD, 3'd1, 3'd1, 3'd1, 32'd0, lat, nb);
        checks++;
        if (result !== 32'd10) begin errors++; $display("FAIL alias_add: got %h want a", result); end
        run_cmd(ADD, 3'd7, 3'd1, 3'd0, 32'd0, lat, nb);
        checks++;
        if (disp_value !== 32'd10) begin errors++; $display("FAIL alias_disp: got %h want a", disp_value); end
    endtask

    task automatic test_logic();
        int lat, nb;
        run_cmd(LDI, 3'd1, 3'd0, 3'd0, 32'hFF00_FF00, lat, nb);
        run_cmd(LDI, 3'd2, 3'd0, 3'd0, 32'h0F0F_0F0F, lat, nb);
        run_cmd(AND, 3'd3, 3'd1, 3'd2, 32'd0, lat, nb);
        checks++;
        if (result !== 32'h0F00_0F00 || {O, C, Z, N} !== 4'b0000) begin
            errors++; $display("FAIL and_op: got res=%h ocnz=%b%b%b%b want 0f000f00/0000", result, O, C, Z, N);
        end
        run_cmd(OR, 3'd3, 3'd1, 3'd2, 32'd0, lat, nb);
        checks++;
        if (result !== 32'hFF0F_FF0F || {O, C, Z, N} !== 4'b0001) begin
            errors++; $display("FAIL or_op: got res=%h ocnz=%b%b%b%b want ff0fff0f/0001", result, O, C, Z, N);
        end
        run_cmd(XOR, 3'd3, 3'd1, 3'd2, 32'd0, lat, nb);
        checks++;
        if (result !== 32'hF00F_F00F || {O, C, Z, N} !== 4'b0001) begin
            errors++; $display("FAIL xor_op: got res=%h ocnz=%b%b%b%b want f00ff00f/0001", result, O, C, Z, N);
        end
    endtask

    task automatic test_shift();
        int lat, nb;
        run_cmd(LDI, 3'd1, 3'd0, 3'd0, 32'h8000_0001, lat, nb);
        run_cmd(LDI, 3'd2, 3'd0, 3'd0, 32'h0000_0021, lat, nb);
        // 0x21 - 0x80000001: borrow and signed overflow
        run_cmd(SUB, 3'd6, 3'd2, 3'd1, 32'd0, lat, nb);
        checks++;
        if (result !== 32'h8000_0020 || {O, C, Z, N} !== 4'b1101) begin
            errors++; $display("FAIL sub_ovf: got res=%h ocnz=%b%b%b%b want 80000020/1101", result, O, C, Z, N);
        end
        run_cmd(SLL, 3'd5, 3'd1, 3'd2, 32'd0, lat, nb);
        checks++;
        if (result !== 32'h0000_0002 || {O, C, Z, N} !== 4'b0000) begin
            errors++; $display("FAIL sll_op: got res=%h ocnz=%b%b%b%b want 00000002/0000", result, O, C, Z, N);
        end
        run_cmd(SRL, 3'd5, 3'd1, 3'd2, 32'd0, lat, nb);
        checks++;
        if (result !== 32'h4000_0000 || {O, C, Z, N} !== 4'b0000) begin
            errors++; $display("FAIL srl_op: got res=%h ocnz=%b%b%b%b want 40000000/0000", result, O, C, Z, N);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got [4];
        int ndone = 0;
        // Valid held high with a new LDI r7 each cycle: only cycles 0, 4, 8 are accepted
        for (int i = 0; i < 12; i++) begin
            cmd_valid = 1'b1;
            cmd       = {LDI, 3'd7, 3'd0, 3'd0};
            cmd_imm   = 32'h100 + i;
            @(posedge clk); #1;
            if (done) begin
                if (ndone < 4) got[ndone] = result;
                ndone++;
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (ndone !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", ndone); end
        checks++;
        if (ndone >= 3 && (got[0] !== 32'h100 || got[1] !== 32'h104 || got[2] !== 32'h108)) begin
            errors++; $display("FAIL b2b_values: got %h %h %h want 100 104 108", got[0], got[1], got[2]);
        end
        checks++;
        if (disp_value !== 32'h108) begin errors++; $display("FAIL b2b_disp: got %h want 108", disp_value); end
    endtask

    task automatic test_reset_in_exec();
        int lat, nb, ndone;
        cmd_valid = 1'b1;
        cmd       = {LDI, 3'd7, 3'd0, 3'd0};
        cmd_imm   = 32'hDEAD;
        @(posedge clk); #1;          // accepted, now READ
        cmd_valid = 1'b0;
        @(posedge clk); #1;          // now EXEC
        reset = 1'b1;
        #1;
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", ndone); end
        checks++;
        if (disp_value !== 32'd0 || result !== 32'd0 || {O, C, Z, N} !== 4'b0000) begin
            errors++; $display("FAIL abort_state: got disp=%h res=%h ocnz=%b%b%b%b want zeros",
                               disp_value, result, O, C, Z, N);
        end
        run_cmd(LDI, 3'd7, 3'd0, 3'd0, 32'h55, lat, nb);
        checks++;
        if (lat !== 3 || disp_value !== 32'h55) begin
            errors++; $display("FAIL post_reset_cmd: got lat=%0d disp=%h want 3/55", lat, disp_value);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_async_reset();
        test_sub();
        test_alias();
        test_logic();
        test_shift();
        test_back_to_back();
        test_reset_in_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
